mapper_irq_controller: RTL and testbench



---
 rtl/mapper_irq_pkg.sv | 43 ++++
 rtl/irq_prescaler.sv | 47 ++++
 rtl/mapper_irq_controller.sv | 158 +++++++++++++++
 tb/tb_mapper_irq_controller.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mapper_irq_pkg.sv
// Shared definitions for the cartridge mapper IRQ controller:
// register map, control/enable/ack bit positions and status layout.
package mapper_irq_pkg;

  localparam logic [2:0] IRQ_REG_A_LO    = 3'd0;
  localparam logic [2:0] IRQ_REG_A_HI    = 3'd1;
  localparam logic [2:0] IRQ_REG_B_LATCH = 3'd2;
  localparam logic [2:0] IRQ_REG_B_CTRL  = 3'd3;
  localparam logic [2:0] IRQ_REG_B_ACK   = 3'd4;
  localparam logic [2:0] IRQ_REG_ENABLE  = 3'd5;
  localparam logic [2:0] IRQ_REG_ACK     = 3'd6;
  localparam logic [2:0] IRQ_REG_STATUS  = 3'd7;

  localparam int B_CTRL_ENABLE_AFTER_ACK = 0;
  localparam int B_CTRL_ENABLE           = 1;
  localparam int B_CTRL_CYCLE_MODE       = 2;

  localparam int EN_A_IRQ   = 0;
  localparam int EN_A_COUNT = 1;
  localparam int EN_EXT     = 2;

  localparam int ACK_A   = 0;
  localparam int ACK_EXT = 2;

  localparam int STAT_A   = 0;
  localparam int STAT_B   = 1;
  localparam int STAT_EXT = 2;

  typedef struct packed {
    logic cycleMode;
    logic enable;
    logic enableAfterAck;
  } bCtrl_t;

  function automatic bCtrl_t decodeBCtrl(input logic [7:0] data);
    bCtrl_t ctrl;
    ctrl.cycleMode      = data[B_CTRL_CYCLE_MODE];
    ctrl.enable         = data[B_CTRL_ENABLE];
    ctrl.enableAfterAck = data[B_CTRL_ENABLE_AFTER_ACK];
    return ctrl;
  endfunction

endpackage

// File: rtl/irq_prescaler.sv
// Scanline prescaler for timer B: a signed accumulator that loses STEP per
// cycle and emits a one-cycle tick each time it crosses zero.
module irq_prescaler #(
  parameter int PERIOD = 341,
  parameter int STEP   = 3
) (
  input  logic m2_i,
  input  logic rst_n_i,
  input  logic enable_i,
  input  logic restart_i,
  output logic tick_o
);

  // Wide enough to hold PERIOD as a positive signed value.
  localparam int AccW = $clog2(PERIOD + 1) + 1;
  localparam logic signed [AccW-1:0] PeriodS = AccW'(PERIOD);
  localparam logic signed [AccW-1:0] StepS   = AccW'(STEP);

  logic signed [AccW-1:0] acc_q;
  logic signed [AccW-1:0] acc_d;
  logic signed [AccW-1:0] accDec;

  always_comb begin
    accDec = acc_q - StepS;
    acc_d  = acc_q;
    tick_o = 1'b0;
    if (restart_i) begin
      acc_d = PeriodS;
    end else if (enable_i) begin
      if (accDec[AccW-1] || (accDec == '0)) begin
        acc_d  = accDec + PeriodS;
        tick_o = 1'b1;
      end else begin
        acc_d = accDec;
      end
    end
  end

  always_ff @(negedge m2_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc_q <= PeriodS;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/mapper_irq_controller.sv
// Shared cartridge IRQ controller: CPU-cycle timer A, scanline/cycle timer B
// and a synchronised external request, merged onto one active-low irq line.
module mapper_irq_controller
  import mapper_irq_pkg::*;
#(
  parameter int PRESCALE_PERIOD = 341,
  parameter int PRESCALE_STEP   = 3
) (
  input  logic       m2,
  input  logic       rst_n,
  input  logic       reg_we,
  input  logic       reg_re,
  input  logic [2:0] reg_addr,
  input  logic [7:0] reg_data,
  input  logic       ext_irq_req,
  output logic [7:0] status_out,
  output logic       status_oe,
  output logic       irq
);

  logic [15:0] aCount_q, aCount_d;
  logic        aIrqEn_q, aIrqEn_d;
  logic        aCountEn_q, aCountEn_d;
  logic        extEn_q, extEn_d;
  logic [7:0]  bLatch_q, bLatch_d;
  logic [7:0]  bCount_q, bCount_d;
  bCtrl_t      bCtrl_q, bCtrl_d;
  logic        pendA_q, pendA_d;
  logic        pendB_q, pendB_d;
  logic        pendExt_q, pendExt_d;
  logic [2:0]  extSync_q, extSync_d;

  logic wrALo, wrAHi, wrBLatch, wrBCtrl, wrBAck, wrEnable, wrAck;
  logic aEvent, bEvent, extEvent, bTick, prescTick, bRestart;

  assign wrALo    = reg_we && (reg_addr == IRQ_REG_A_LO);
  assign wrAHi    = reg_we && (reg_addr == IRQ_REG_A_HI);
  assign wrBLatch = reg_we && (reg_addr == IRQ_REG_B_LATCH);
  assign wrBCtrl  = reg_we && (reg_addr == IRQ_REG_B_CTRL);
  assign wrBAck   = reg_we && (reg_addr == IRQ_REG_B_ACK);
  assign wrEnable = reg_we && (reg_addr == IRQ_REG_ENABLE);
  assign wrAck    = reg_we && (reg_addr == IRQ_REG_ACK);

  assign bRestart = wrBCtrl && reg_data[B_CTRL_ENABLE];

  irq_prescaler #(
    .PERIOD (PRESCALE_PERIOD),
    .STEP   (PRESCALE_STEP)
  ) uPrescaler (
    .m2_i      (m2),
    .rst_n_i   (rst_n),
    .enable_i  (bCtrl_q.enable && !bCtrl_q.cycleMode),
    .restart_i (bRestart),
    .tick_o    (prescTick)
  );

  // A CPU write to either count byte takes precedence over that cycle's decrement.
  always_comb begin
    aCount_d   = aCount_q;
    aEvent     = 1'b0;
    aIrqEn_d   = aIrqEn_q;
    aCountEn_d = aCountEn_q;
    extEn_d    = extEn_q;
    if (wrALo) begin
      aCount_d = {aCount_q[15:8], reg_data};
    end else if (wrAHi) begin
      aCount_d = {reg_data, aCount_q[7:0]};
    end else if (aCountEn_q) begin
      aCount_d = aCount_q - 16'd1;
      aEvent   = aIrqEn_q && (aCount_q == 16'h0000);
    end
    if (wrEnable) begin
      aIrqEn_d   = reg_data[EN_A_IRQ];
      aCountEn_d = reg_data[EN_A_COUNT];
      extEn_d    = reg_data[EN_EXT];
    end
  end

  assign bTick = bCtrl_q.enable && (bCtrl_q.cycleMode || prescTick);

  always_comb begin
    bLatch_d = wrBLatch ? reg_data : bLatch_q;
    bCount_d = bCount_q;
    bCtrl_d  = bCtrl_q;
    bEvent   = 1'b0;
    if (wrBCtrl) begin
      bCtrl_d = decodeBCtrl(reg_data);
      if (reg_data[B_CTRL_ENABLE]) begin
        bCount_d = bLatch_q;
      end
    end else if (bTick) begin
      if (bCount_q == 8'hFF) begin
        bCount_d = bLatch_q;
        bEvent   = 1'b1;
      end else begin
        bCount_d = bCount_q + 8'd1;
      end
    end
    if (wrBAck) begin
      bCtrl_d.enable = bCtrl_q.enableAfterAck;
    end
  end

  assign extSync_d = {extSync_q[1:0], ext_irq_req};
  assign extEvent  = extEn_q && extSync_q[1] && !extSync_q[2];

  // Acks are applied first so a coincident source event leaves the bit set.
  always_comb begin
    pendA_d   = pendA_q;
    pendB_d   = pendB_q;
    pendExt_d = pendExt_q;
    if (wrAck && reg_data[ACK_A])   pendA_d = 1'b0;
    if (wrAck && reg_data[ACK_EXT]) pendExt_d = 1'b0;
    if (wrBAck || bRestart)         pendB_d = 1'b0;
    if (aEvent)                     pendA_d = 1'b1;
    if (bEvent)                     pendB_d = 1'b1;
    if (extEvent)                   pendExt_d = 1'b1;
  end

  always_ff @(negedge m2 or negedge rst_n) begin
    if (!rst_n) begin
      aCount_q   <= '0;
      aIrqEn_q   <= 1'b0;
      aCountEn_q <= 1'b0;
      extEn_q    <= 1'b0;
      bLatch_q   <= '0;
      bCount_q   <= '0;
      bCtrl_q    <= '0;
      pendA_q    <= 1'b0;
      pendB_q    <= 1'b0;
      pendExt_q  <= 1'b0;
      extSync_q  <= '0;
    end else begin
      aCount_q   <= aCount_d;
      aIrqEn_q   <= aIrqEn_d;
      aCountEn_q <= aCountEn_d;
      extEn_q    <= extEn_d;
      bLatch_q   <= bLatch_d;
      bCount_q   <= bCount_d;
      bCtrl_q    <= bCtrl_d;
      pendA_q    <= pendA_d;
      pendB_q    <= pendB_d;
      pendExt_q  <= pendExt_d;
      extSync_q  <= extSync_d;
    end
  end

  always_comb begin
    status_out           = '0;
    status_out[STAT_A]   = pendA_q;
    status_out[STAT_B]   = pendB_q;
    status_out[STAT_EXT] = pendExt_q;
  end

  assign status_oe = reg_re && (reg_addr == IRQ_REG_STATUS);
  assign irq       = ~(pendA_q | pendB_q | pendExt_q);

endmodule

// File: tb/tb_mapper_irq_controller.sv
// Directed bench for mapper_irq_controller: a per-cycle vector table for
// register behaviour plus hand-timed sequences for timers, sync and collisions.
module tb_mapper_irq_controller;

  logic       m2;
  logic       rst_n;
  logic       reg_we;
  logic       reg_re;
  logic [2:0] reg_addr;
  logic [7:0] reg_data;
  logic       ext_irq_req;
  logic [7:0] status_out;
  logic       status_oe;
  logic       irq;

  int checks = 0;
  int errors = 0;

  mapper_irq_controller #(
    .PRESCALE_PERIOD (341),
    .PRESCALE_STEP   (3)
  ) dut (
    .m2          (m2),
    .rst_n       (rst_n),
    .reg_we      (reg_we),
    .reg_re      (reg_re),
    .reg_addr    (reg_addr),
    .reg_data    (reg_data),
    .ext_irq_req (ext_irq_req),
    .status_out  (status_out),
    .status_oe   (status_oe),
    .irq         (irq)
  );

  initial m2 = 1'b1;
  always #5 m2 = ~m2;

  typedef struct {
    logic       we;
    logic       re;
    logic [2:0] addr;
    logic [7:0] data;
    logic [7:0] expStatus;
    logic       expOe;
    logic       expIrq;
  } vec_t;

  vec_t vecs[11];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic re, input logic [2:0] addr,
                               input logic [7:0] data);
    reg_we   = we;
    reg_re   = re;
    reg_addr = addr;
    reg_data = data;
  endtask

  // Advance across one falling (active) edge and settle past the next rising edge.
  task automatic step();
    @(negedge m2);
    @(posedge m2);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic writeReg(input logic [2:0] addr, input logic [7:0] data);
    applyStimulus(1'b1, 1'b0, addr, data);
    step();
    reg_we = 1'b0;
  endtask

  task automatic waitIrq(input int maxCycles, output int n);
    n = -1;
    for (int i = 1; i <= maxCycles; i++) begin
      step();
      if (irq == 1'b0) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int lowCount;

    vecs[0]  = '{1'b0, 1'b1, 3'd7, 8'h00, 8'h00, 1'b1, 1'b1};
    vecs[1]  = '{1'b1, 1'b0, 3'd7, 8'hFF, 8'h00, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 1'b0, 3'd0, 8'h01, 8'h00, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 3'd1, 8'h00, 8'h00, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 3'd5, 8'h03, 8'h00, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 3'd7, 8'h00, 8'h00, 1'b1, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 3'd7, 8'h00, 8'h01, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 3'd0, 8'h00, 8'h01, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 3'd6, 8'h04, 8'h01, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 3'd6, 8'h01, 8'h00, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 3'd5, 8'h00, 8'h00, 1'b0, 1'b1};

    rst_n       = 1'b0;
    ext_irq_req = 1'b0;
    applyStimulus(1'b0, 1'b0, 3'd0, 8'h00);
    #2;
    checkOutput("reset irq", int'(irq), 1);
    checkOutput("reset status", int'(status_out), 0);
    checkOutput("reset status_oe", int'(status_oe), 0);
    @(posedge m2);
    #1;
    rst_n = 1'b1;

    lowCount = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (irq == 1'b0) lowCount++;
    end
    checkOutput("idle 1000 cycles irq low count", lowCount, 0);

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].data);
      step();
      checkOutput($sformatf("vec%0d status", i), int'(status_out), int'(vecs[i].expStatus));
      checkOutput($sformatf("vec%0d status_oe", i), int'(status_oe), int'(vecs[i].expOe));
      checkOutput($sformatf("vec%0d irq", i), int'(irq), int'(vecs[i].expIrq));
    end
    applyStimulus(1'b0, 1'b0, 3'd0, 8'h00);

    // Timer A: load 5, enable -> wrap six cycles later.
    writeReg(3'd0, 8'h05);
    writeReg(3'd1, 8'h00);
    writeReg(3'd5, 8'h03);
    waitIrq(20, n);
    checkOutput("timer A latency", n, 6);
    checkOutput("timer A status", int'(status_out), 8'h01);
    writeReg(3'd6, 8'h01);
    checkOutput("timer A ack irq", int'(irq), 1);
    writeReg(3'd5, 8'h00);

    // Timer B cycle mode, latch 0xFC.
    writeReg(3'd2, 8'hFC);
    writeReg(3'd3, 8'h07);
    waitIrq(20, n);
    checkOutput("timer B cycle latency", n, 4);
    checkOutput("timer B cycle status", int'(status_out), 8'h02);
    writeReg(3'd4, 8'h00);
    checkOutput("timer B ack status", int'(status_out), 8'h00);
    waitIrq(20, n);
    checkOutput("timer B reload to latch", n, 3);
    idle(3);
    writeReg(3'd4, 8'h00);
    checkOutput("timer B event beats ack", int'(status_out), 8'h02);
    writeReg(3'd4, 8'h00);
    checkOutput("timer B plain ack", int'(status_out), 8'h00);

    writeReg(3'd3, 8'h06);
    waitIrq(20, n);
    checkOutput("timer B reg3 restart latency", n, 4);
    writeReg(3'd4, 8'h00);
    checkOutput("timer B ack disables", int'(status_out), 8'h00);
    waitIrq(300, n);
    checkOutput("timer B stopped", n, -1);

    // Timer B scanline mode, latch 0xFE: ticks at 114, 228, 341, 455.
    writeReg(3'd2, 8'hFE);
    writeReg(3'd3, 8'h03);
    waitIrq(400, n);
    checkOutput("timer B scanline first", n, 228);
    writeReg(3'd4, 8'h00);
    waitIrq(400, n);
    checkOutput("timer B scanline second", n, 226);
    writeReg(3'd3, 8'h00);
    writeReg(3'd4, 8'h00);
    checkOutput("timer B scanline off", int'(status_out), 8'h00);

    // External request through the synchroniser.
    writeReg(3'd5, 8'h04);
    ext_irq_req = 1'b1;
    waitIrq(10, n);
    checkOutput("ext latency", n, 3);
    checkOutput("ext status", int'(status_out), 8'h04);
    ext_irq_req = 1'b0;
    idle(5);
    ext_irq_req = 1'b1;
    idle(2);
    writeReg(3'd6, 8'h04);
    checkOutput("ext event beats ack", int'(status_out), 8'h04);
    writeReg(3'd5, 8'h00);
    checkOutput("ext_en clear keeps pending", int'(status_out), 8'h04);
    writeReg(3'd6, 8'h04);
    checkOutput("ext ack", int'(status_out), 8'h00);
    ext_irq_req = 1'b0;

    // Reg 3 write on the overflow cycle wins.
    writeReg(3'd2, 8'hFC);
    writeReg(3'd3, 8'h06);
    idle(3);
    writeReg(3'd3, 8'h06);
    checkOutput("reg3 beats overflow status", int'(status_out), 8'h00);
    waitIrq(20, n);
    checkOutput("reg3 beats overflow reload", n, 4);
    writeReg(3'd3, 8'h00);
    writeReg(3'd4, 8'h00);
    checkOutput("timer B off", int'(status_out), 8'h00);

    // Timer A: write beats decrement, then wrap coincides with ack.
    writeReg(3'd1, 8'h00);
    writeReg(3'd0, 8'h10);
    writeReg(3'd5, 8'h03);
    idle(4);
    writeReg(3'd0, 8'h02);
    checkOutput("timer A write cycle status", int'(status_out), 8'h00);
    idle(2);
    checkOutput("timer A write beats decrement", int'(status_out), 8'h00);
    writeReg(3'd6, 8'h01);
    checkOutput("timer A event beats ack", int'(status_out), 8'h01);

    // Asynchronous reset mid-count.
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset irq", int'(irq), 1);
    checkOutput("async reset status", int'(status_out), 8'h00);
    @(posedge m2);
    #1;
    rst_n = 1'b1;
    writeReg(3'd0, 8'h01);
    waitIrq(20, n);
    checkOutput("async reset cleared enables", n, -1);
    checkOutput("post reset status", int'(status_out), 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
